// File: rtl/lift_pkg.sv
// Shared constants, encodings and small helpers for the lift call scheduler.
package lift_pkg;

    localparam int NUM_FLOORS = 4;

    localparam logic [2:0] CALL_1U = 3'b001;
    localparam logic [2:0] CALL_2U = 3'b010;
    localparam logic [2:0] CALL_3U = 3'b011;
    localparam logic [2:0] CALL_2D = 3'b110;
    localparam logic [2:0] CALL_3D = 3'b111;
    localparam logic [2:0] CALL_4D = 3'b100;

    localparam logic [1:0] DIR_IDLE = 2'b00;
    localparam logic [1:0] DIR_UP   = 2'b01;
    localparam logic [1:0] DIR_DOWN = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'b00,
        ST_MOVE_UP   = 2'b01,
        ST_MOVE_DOWN = 2'b10,
        ST_SERVE     = 2'b11
    } state_t;

    typedef struct packed {
        logic [3:0] up;
        logic [3:0] dn;
    } hall_set_t;

    function automatic hall_set_t decode_call(input logic vld, input logic [2:0] code);
        hall_set_t r;
        r.up = 4'b0000;
        r.dn = 4'b0000;
        if (vld) begin
            case (code)
                CALL_1U: r.up = 4'b0001;
                CALL_2U: r.up = 4'b0010;
                CALL_3U: r.up = 4'b0100;
                CALL_2D: r.dn = 4'b0010;
                CALL_3D: r.dn = 4'b0100;
                CALL_4D: r.dn = 4'b1000;
                default: r.up = 4'b0000;
            endcase
        end else begin
            r.dn = 4'b0000;
        end
        return r;
    endfunction

    function automatic logic [3:0] floor_onehot(input logic [1:0] f);
        return 4'b0001 << f;
    endfunction

    function automatic logic [3:0] above_mask(input logic [1:0] f);
        return 4'b1110 << f;
    endfunction

    function automatic logic [3:0] below_mask(input logic [1:0] f);
        return ~(4'b1111 << f);
    endfunction

    function automatic logic [1:0] lowest_idx(input logic [3:0] v);
        logic [1:0] r;
        r = 2'd0;
        for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
            if (v[i]) r = 2'(i);
        end
        return r;
    endfunction

    function automatic logic [1:0] highest_idx(input logic [3:0] v);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (v[i]) r = 2'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/lift_target_sel.sv
// Combinational sweep-direction target selector over the latched request vectors.
module lift_target_sel
    import lift_pkg::*;
(
    input  logic [3:0] up_pend,
    input  logic [3:0] dn_pend,
    input  logic [3:0] car_pend,
    input  logic [1:0] cur_floor,
    input  logic [1:0] dir,
    output logic       target_vld,
    output logic [1:0] target_floor
);

    logic [3:0] ahead_s;
    logic [3:0] pri_s;
    logic [3:0] alt_s;

    // The current floor stays in the search so the target survives until arrival.
    assign ahead_s = (dir == DIR_UP) ? ~below_mask(cur_floor) : ~above_mask(cur_floor);

    // Primary set: same-direction stops; alternate: farthest reversal hall call.
    always_comb begin
        pri_s        = 4'b0000;
        alt_s        = 4'b0000;
        target_vld   = 1'b0;
        target_floor = 2'd0;
        case (dir)
            DIR_UP: begin
                pri_s = (car_pend | up_pend) & ahead_s;
                alt_s = dn_pend & ahead_s;
            end
            DIR_DOWN: begin
                pri_s = (car_pend | dn_pend) & ahead_s;
                alt_s = up_pend & ahead_s;
            end
            default: begin
                pri_s = 4'b0000;
                alt_s = 4'b0000;
            end
        endcase
        if (|pri_s) begin
            target_vld   = 1'b1;
            target_floor = (dir == DIR_UP) ? lowest_idx(pri_s) : highest_idx(pri_s);
        end else if (|alt_s) begin
            target_vld   = 1'b1;
            target_floor = (dir == DIR_UP) ? highest_idx(alt_s) : lowest_idx(alt_s);
        end else begin
            target_vld   = 1'b0;
            target_floor = 2'd0;
        end
    end

endmodule

// File: rtl/lift_call_scheduler.sv
// Hall/car call latching and sweep scheduling for a four-floor lift.
module lift_call_scheduler
    import lift_pkg::*;
#(
    parameter int DWELL_CYC = 4
)
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       call_vld,
    input  logic [2:0] call_code,
    input  logic       car_vld,
    input  logic [1:0] car_floor,
    input  logic [1:0] cur_floor,
    input  logic       arrived,
    output logic       target_vld,
    output logic [1:0] target_floor,
    output logic [1:0] dir,
    output logic       door_open,
    output logic [3:0] up_pend,
    output logic [3:0] dn_pend,
    output logic [3:0] car_pend
);

    state_t     state_r, state_nxt_s;
    logic [1:0] sweep_r, sweep_nxt_s;
    logic [3:0] cnt_r, cnt_nxt_s;
    logic [3:0] up_r, dn_r, car_r;

    hall_set_t  hall_s;
    logic [3:0] car_set_s, cur_oh_s, above_s, below_s;
    logic [3:0] up_eff_s, dn_eff_s, car_eff_s, any_s;
    logic [3:0] up_clr_s, dn_clr_s, car_clr_s;
    logic       at_cur_s, any_above_s, any_below_s, up_wins_s;
    logic       fwd_s, back_s, serve_entry_s;
    logic [1:0] lo_above_s, hi_below_s;
    logic       sel_vld_s;
    logic [1:0] sel_floor_s;

    assign hall_s    = decode_call(call_vld, call_code);
    assign car_set_s = car_vld ? floor_onehot(car_floor) : 4'b0000;
    assign cur_oh_s  = floor_onehot(cur_floor);
    assign above_s   = above_mask(cur_floor);
    assign below_s   = below_mask(cur_floor);

    lift_target_sel u_target_sel (
        .up_pend      (up_r),
        .dn_pend      (dn_r),
        .car_pend     (car_r),
        .cur_floor    (cur_floor),
        .dir          (dir),
        .target_vld   (sel_vld_s),
        .target_floor (sel_floor_s)
    );

    // Merge new requests; while the door is open, same-direction calls here are absorbed.
    always_comb begin
        up_eff_s  = up_r | hall_s.up;
        dn_eff_s  = dn_r | hall_s.dn;
        car_eff_s = car_r | car_set_s;
        if (state_r == ST_SERVE) begin
            car_eff_s = car_eff_s & ~cur_oh_s;
            if (sweep_r == DIR_UP) begin
                up_eff_s = up_eff_s & ~cur_oh_s;
            end else begin
                dn_eff_s = dn_eff_s & ~cur_oh_s;
            end
        end else begin
            car_eff_s = car_eff_s;
        end
    end

    assign any_s       = up_eff_s | dn_eff_s | car_eff_s;
    assign at_cur_s    = |(any_s & cur_oh_s);
    assign any_above_s = |(any_s & above_s);
    assign any_below_s = |(any_s & below_s);
    assign lo_above_s  = lowest_idx(any_s & above_s);
    assign hi_below_s  = highest_idx(any_s & below_s);
    assign up_wins_s   = any_above_s &&
                         (!any_below_s || ((lo_above_s - cur_floor) <= (cur_floor - hi_below_s)));
    assign fwd_s       = (sweep_r == DIR_UP) ? any_above_s : any_below_s;
    assign back_s      = (sweep_r == DIR_UP) ? any_below_s : any_above_s;

    // Next-state and sweep-direction selection.
    always_comb begin
        state_nxt_s = state_r;
        sweep_nxt_s = sweep_r;
        case (state_r)
            ST_IDLE: begin
                if (at_cur_s) begin
                    state_nxt_s = ST_SERVE;
                    sweep_nxt_s = (up_eff_s[cur_floor] || !dn_eff_s[cur_floor]) ? DIR_UP : DIR_DOWN;
                end else if (up_wins_s) begin
                    state_nxt_s = ST_MOVE_UP;
                    sweep_nxt_s = DIR_UP;
                end else if (any_below_s) begin
                    state_nxt_s = ST_MOVE_DOWN;
                    sweep_nxt_s = DIR_DOWN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_MOVE_UP, ST_MOVE_DOWN: begin
                if (!sel_vld_s) begin
                    state_nxt_s = ST_IDLE;
                end else if (arrived && (cur_floor == sel_floor_s)) begin
                    state_nxt_s = ST_SERVE;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_SERVE: begin
                if (cnt_r > 4'd1) begin
                    state_nxt_s = ST_SERVE;
                end else if (fwd_s) begin
                    state_nxt_s = (sweep_r == DIR_UP) ? ST_MOVE_UP : ST_MOVE_DOWN;
                end else if (back_s) begin
                    state_nxt_s = (sweep_r == DIR_UP) ? ST_MOVE_DOWN : ST_MOVE_UP;
                    sweep_nxt_s = (sweep_r == DIR_UP) ? DIR_DOWN : DIR_UP;
                end else if (at_cur_s) begin
                    state_nxt_s = ST_SERVE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    assign serve_entry_s = (state_nxt_s == ST_SERVE) &&
                           ((state_r != ST_SERVE) || (cnt_r == 4'd1));

    // Stop clears; the opposite hall call goes too only when nothing lies ahead.
    always_comb begin
        up_clr_s  = 4'b0000;
        dn_clr_s  = 4'b0000;
        car_clr_s = 4'b0000;
        cnt_nxt_s = 4'd0;
        if (serve_entry_s) begin
            car_clr_s = cur_oh_s;
            cnt_nxt_s = 4'(DWELL_CYC);
            if (sweep_nxt_s == DIR_UP) begin
                up_clr_s = cur_oh_s;
                dn_clr_s = any_above_s ? 4'b0000 : cur_oh_s;
            end else begin
                dn_clr_s = cur_oh_s;
                up_clr_s = any_below_s ? 4'b0000 : cur_oh_s;
            end
        end else if (state_r == ST_SERVE && state_nxt_s == ST_SERVE) begin
            cnt_nxt_s = cnt_r - 4'd1;
        end else begin
            cnt_nxt_s = 4'd0;
        end
    end

    // State, dwell counter and request registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            sweep_r <= DIR_UP;
            cnt_r   <= 4'd0;
            up_r    <= 4'b0000;
            dn_r    <= 4'b0000;
            car_r   <= 4'b0000;
        end else begin
            state_r <= state_nxt_s;
            sweep_r <= sweep_nxt_s;
            cnt_r   <= cnt_nxt_s;
            up_r    <= up_eff_s & ~up_clr_s & 4'b0111;
            dn_r    <= dn_eff_s & ~dn_clr_s & 4'b1110;
            car_r   <= car_eff_s & ~car_clr_s;
        end
    end

    // Outputs decoded from registered state.
    always_comb begin
        dir          = (state_r == ST_IDLE) ? DIR_IDLE : sweep_r;
        door_open    = (state_r == ST_SERVE);
        target_vld   = ((state_r == ST_MOVE_UP) || (state_r == ST_MOVE_DOWN)) && sel_vld_s;
        target_floor = target_vld ? sel_floor_s : 2'd0;
    end

    assign up_pend  = up_r;
    assign dn_pend  = dn_r;
    assign car_pend = car_r;

endmodule

// File: tb/tb_lift_call_scheduler.sv
// Directed vector bench for lift_call_scheduler with hand-computed expectations.
module tb_lift_call_scheduler;

    logic       clk = 1'b0;
    logic       rst_n, call_vld, car_vld, arrived;
    logic [2:0] call_code;
    logic [1:0] car_floor, cur_floor;
    logic       target_vld, door_open;
    logic [1:0] target_floor, dir;
    logic [3:0] up_pend, dn_pend, car_pend;

    int tests = 0;
    int fails = 0;

    lift_call_scheduler #(.DWELL_CYC(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .call_vld     (call_vld),
        .call_code    (call_code),
        .car_vld      (car_vld),
        .car_floor    (car_floor),
        .cur_floor    (cur_floor),
        .arrived      (arrived),
        .target_vld   (target_vld),
        .target_floor (target_floor),
        .dir          (dir),
        .door_open    (door_open),
        .up_pend      (up_pend),
        .dn_pend      (dn_pend),
        .car_pend     (car_pend)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic        cv;
        logic [2:0]  code;
        logic        kv;
        logic [1:0]  kf;
        logic [1:0]  cur;
        logic        arr;
        logic [17:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic cv, input logic [2:0] code,
                                input logic kv, input logic [1:0] kf, input logic [1:0] cur,
                                input logic arr, input logic tv, input logic [1:0] tf,
                                input logic [1:0] dr, input logic door, input logic [3:0] up,
                                input logic [3:0] dn, input logic [3:0] car);
        vec_t v;
        v.rst_n = r; v.cv = cv; v.code = code; v.kv = kv; v.kf = kf;
        v.cur = cur; v.arr = arr;
        v.exp = {tv, tf, dr, door, up, dn, car};
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        int n;
        rst_n = 1'b0; call_vld = 1'b0; call_code = 3'b000; car_vld = 1'b0;
        car_floor = 2'd0; cur_floor = 2'd0; arrived = 1'b0;

        //             rst cv code    kv kf    cur   arr  tv tf    dir    door up       dn       car
        vecs.push_back(mk(1'b0,1'b1,3'b011,1'b1,2'd1,2'd0,1'b0, 1'b0,2'd0,2'b00,1'b0,4'b0000,4'b0000,4'b0000));
        vecs.push_back(mk(1'b1,1'b1,3'b011,1'b0,2'd0,2'd0,1'b0, 1'b1,2'd2,2'b01,1'b0,4'b0100,4'b0000,4'b0000));
        vecs.push_back(mk(1'b1,1'b0,3'b000,1'b0,2'd0,2'd1,1'b0, 1'b1,2'd2,2'b01,1'b0,4'b0100,4'b0000,4'b0000));
        vecs.push_back(mk(1'b1,1'b0,3'b000,1'b0,2'd0,2'd2,1'b0, 1'b1,2'd2,2'b01,1'b0,4'b0100,4'b0000,4'b0000));
        vecs.push_back(mk(1'b1,1'b0,3'b000,1'b0,2'd0,2'd2,1'b1, 1'b0,2'd0,2'b01,1'b1,4'b0000,4'b0000,4'b0000));
        vecs.push_back(mk(1'b1,1'b1,3'b011,1'b0,2'd0,2'd2,1'b0, 1'b0,2'd0,2'b01,1'b1,4'b0000,4'b0000,4'b0000));
        vecs.push_back(mk(1'b1,1'b1,3'b000,1'b0,2'd0,2'd2,1'b0, 1'b0,2'd0,2'b01,1'b1,4'b0000,4'b0000,4'b0000));
        vecs.push_back(mk(1'b1,1'b1,3'b101,1'b0,2'd0,2'd2,1'b0, 1'b0,2'd0,2'b01,1'b1,4'b0000,4'b0000,4'b0000));
        vecs.push_back(mk(1'b1,1'b0,3'b000,1'b0,2'd0,2'd2,1'b0, 1'b0,2'd0,2'b00,1'b0,4'b0000,4'b0000,4'b0000));
        vecs.push_back(mk(1'b1,1'b1,3'b000,1'b0,2'd0,2'd0,1'b0, 1'b0,2'd0,2'b00,1'b0,4'b0000,4'b0000,4'b0000));
        vecs.push_back(mk(1'b1,1'b1,3'b100,1'b0,2'd0,2'd0,1'b0, 1'b1,2'd3,2'b01,1'b0,4'b0000,4'b1000,4'b0000));
        vecs.push_back(mk(1'b1,1'b0,3'b000,1'b1,2'd1,2'd0,1'b0, 1'b1,2'd1,2'b01,1'b0,4'b0000,4'b1000,4'b0010));
        vecs.push_back(mk(1'b1,1'b0,3'b000,1'b0,2'd0,2'd1,1'b1, 1'b0,2'd0,2'b01,1'b1,4'b0000,4'b1000,4'b0000));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(1'b1,1'b0,3'b000,1'b0,2'd0,2'd1,1'b0, 1'b0,2'd0,2'b01,1'b1,4'b0000,4'b1000,4'b0000));
        vecs.push_back(mk(1'b1,1'b0,3'b000,1'b0,2'd0,2'd1,1'b0, 1'b1,2'd3,2'b01,1'b0,4'b0000,4'b1000,4'b0000));
        vecs.push_back(mk(1'b1,1'b0,3'b000,1'b0,2'd0,2'd3,1'b1, 1'b0,2'd0,2'b01,1'b1,4'b0000,4'b0000,4'b0000));
        vecs.push_back(mk(1'b0,1'b1,3'b001,1'b0,2'd0,2'd3,1'b0, 1'b0,2'd0,2'b00,1'b0,4'b0000,4'b0000,4'b0000));
        vecs.push_back(mk(1'b1,1'b1,3'b001,1'b0,2'd0,2'd1,1'b0, 1'b1,2'd0,2'b10,1'b0,4'b0001,4'b0000,4'b0000));
        vecs.push_back(mk(1'b1,1'b1,3'b100,1'b0,2'd0,2'd1,1'b0, 1'b1,2'd0,2'b10,1'b0,4'b0001,4'b1000,4'b0000));
        vecs.push_back(mk(1'b1,1'b0,3'b000,1'b0,2'd0,2'd0,1'b1, 1'b0,2'd0,2'b10,1'b1,4'b0000,4'b1000,4'b0000));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(1'b1,1'b0,3'b000,1'b0,2'd0,2'd0,1'b0, 1'b0,2'd0,2'b10,1'b1,4'b0000,4'b1000,4'b0000));
        vecs.push_back(mk(1'b1,1'b0,3'b000,1'b0,2'd0,2'd0,1'b0, 1'b1,2'd3,2'b01,1'b0,4'b0000,4'b1000,4'b0000));
        vecs.push_back(mk(1'b1,1'b0,3'b000,1'b0,2'd0,2'd2,1'b1, 1'b1,2'd3,2'b01,1'b0,4'b0000,4'b1000,4'b0000));
        vecs.push_back(mk(1'b1,1'b0,3'b000,1'b0,2'd0,2'd3,1'b1, 1'b0,2'd0,2'b01,1'b1,4'b0000,4'b0000,4'b0000));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(1'b1,1'b0,3'b000,1'b0,2'd0,2'd3,1'b0, 1'b0,2'd0,2'b01,1'b1,4'b0000,4'b0000,4'b0000));
        vecs.push_back(mk(1'b1,1'b0,3'b000,1'b0,2'd0,2'd3,1'b0, 1'b0,2'd0,2'b00,1'b0,4'b0000,4'b0000,4'b0000));
        vecs.push_back(mk(1'b1,1'b1,3'b011,1'b1,2'd0,2'd1,1'b0, 1'b1,2'd2,2'b01,1'b0,4'b0100,4'b0000,4'b0001));

        for (int i = 0; i < vecs.size(); i++) begin
            rst_n = vecs[i].rst_n; call_vld = vecs[i].cv; call_code = vecs[i].code;
            car_vld = vecs[i].kv; car_floor = vecs[i].kf; cur_floor = vecs[i].cur;
            arrived = vecs[i].arr;
            tick();
            chk($sformatf("row%0d", i),
                32'({target_vld, target_floor, dir, door_open, up_pend, dn_pend, car_pend}),
                32'(vecs[i].exp));
        end

        // Arrive at floor 2 on the up sweep, then time the door-open window.
        call_vld = 1'b0; car_vld = 1'b0; cur_floor = 2'd2; arrived = 1'b1;
        tick();
        arrived = 1'b0;
        chk("serve_entry_car", 32'(car_pend), 32'h1);
        n = 0;
        while (door_open && n < 20) begin
            n++;
            tick();
        end
        chk("dwell_len", 32'(n), 32'd4);
        chk("reverse_dir", 32'(dir), 32'h2);
        chk("reverse_tgt", 32'({target_vld, target_floor}), 32'h4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/lift_call_scheduler.md
LIFT_CALL_SCHEDULER -- requirements
Module: lift_call_scheduler

Interface
REQ-001 Parameter DWELL_CYC, default 4: door-dwell cycles spent in SERVE, legal range 1..15.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  synchronous, active-low reset.
REQ-004 call_vld  input  1  hall-call strobe, sampled every cycle.
REQ-005 call_code  input  3  hall call; bit2 0=UP/1=DOWN; 001 1U, 010 2U, 011 3U, 110 2D, 111 3D, 100 4D.
REQ-006 car_vld  input  1  car-panel call strobe.
REQ-007 car_floor  input  2  car-call floor index, 0..3 = floors 1..4.
REQ-008 cur_floor  input  2  floor the lift is at or passing, from the lift FSM.
REQ-009 arrived  input  1  one-cycle pulse: lift stopped at cur_floor.
REQ-010 target_vld  output  1  high while target_floor is a valid command.
REQ-011 target_floor  output  2  floor index the lift shall travel to.
REQ-012 dir  output  2  00 IDLE, 01 UP, 10 DOWN, 11 never driven.
REQ-013 door_open  output  1  high throughout SERVE.
REQ-014 up_pend, dn_pend, car_pend  output  4 each  latched requests, bit i = floor index i.

Function
REQ-015 Codes 000 and 101 with call_vld=1 SHALL be ignored; 4U/1D therefore cannot exist (up_pend[3]=dn_pend[0]=0 always).
REQ-016 A valid call or car call SHALL set its pend bit on the next edge; duplicates are no-ops.
REQ-017 States: IDLE, MOVE_UP, MOVE_DOWN, SERVE; dir = 00 in IDLE, else the current sweep direction (retained through SERVE).
REQ-018 IDLE: no pending -> stay; pending at cur_floor -> SERVE; else move toward nearest pending floor, tie -> MOVE_UP.
REQ-019 MOVE_UP target: lowest floor > cur_floor with car_pend or up_pend; if none, highest floor > cur_floor with dn_pend.
REQ-020 MOVE_DOWN target: highest floor < cur_floor with car_pend or dn_pend; if none, lowest floor < cur_floor with up_pend.
REQ-021 target_floor SHALL be recomputed combinationally from registered state each cycle; a new closer call ahead re-targets with zero added latency.
REQ-022 arrived with cur_floor == target_floor SHALL enter SERVE next cycle; arrived elsewhere is ignored.
REQ-023 SERVE entry clears car_pend[cur_floor] and the hall bit in the sweep direction; the opposite hall bit is cleared too only if no request lies beyond cur_floor in the sweep direction, which then reverses.
REQ-024 SERVE lasts exactly DWELL_CYC cycles via a 4-bit down-counter; then IDLE-rule evaluation (REQ-018), honouring the retained direction before reversing.
REQ-025 A call at cur_floor matching the sweep direction arriving during SERVE SHALL be absorbed (not latched); dwell is not restarted.
REQ-026 Set and clear of the same bit in one cycle: clear wins only inside SERVE at cur_floor; otherwise set wins.
REQ-027 MOVE_* with target invalid (all pending cleared) SHALL return to IDLE next cycle, target_vld=0.
REQ-028 target_vld=1 only in MOVE_UP/MOVE_DOWN.

Reset
REQ-029 rst_n=0 at an edge SHALL force IDLE, dir=00, all pend=0, counter=0, target_vld=0, door_open=0, target_floor=0, regardless of state, including mid-SERVE.
REQ-030 Inputs arriving in the cycle of reset SHALL be discarded.

Structure
REQ-031 Shared package lift_pkg holds call-code constants, dir encoding, state enum, NUM_FLOORS=4.
REQ-032 One sub-module lift_target_sel: combinational priority selector implementing REQ-019/020 from pend vectors, cur_floor and dir.

Verification
REQ-033 Reset, cur_floor=0, call 3U -> next cycle up_pend=0100, dir=01, target_floor=2, target_vld=1.
REQ-034 In MOVE_UP toward floor 3 from 0, car_floor=1 at cur_floor=0 -> target_floor=1 same cycle after latch; arrived@1 -> SERVE 4 cycles, car_pend[1]=0.
REQ-035 cur_floor=1 idle, calls 4D and 1U same cycle -> MOVE_DOWN to 0 (nearest, floor 0 distance 1), then 4D served, dir 10->01.
REQ-036 During SERVE at floor 2 dir UP, call 3U -> not latched, door_open stays exactly DWELL_CYC cycles.
REQ-037 Codes 000/101 -> pend unchanged; rst_n=0 mid-SERVE -> all outputs reset values next edge.
